// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the external-SRAM port arbiter: access FSM states,
// one-hot grant encoding and the wait-state counter width.
package sram_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sramState_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_MEM  = 2'b10
  } grant_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake bundle: instruction-fetch read port and
// data-memory read/write port sharing one SRAM controller.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output if_rdata, if_ack, mem_rdata, mem_ack
  );

endinterface

// File: rtl/sram_port_arbiter_prio_arb.sv
// Fixed-priority two-way arbiter: the data port always beats the fetch port.
// Kept standalone so a round-robin policy can be dropped in later.
module sram_prio_arb
  import sram_pkg::*;
(
  input  logic [1:0] req,   // [1] data port, [0] fetch port
  output grant_t     gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (req[1]) begin
      gnt = GNT_MEM;
    end else if (req[0]) begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// External asynchronous SRAM controller shared by the fetch and data ports:
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE, with all outputs registered.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RST,
  sram_port_arbiter_if.slave bus,
  output logic               ram_en_n,
  output logic               ram_oe_n,
  output logic               ram_we_n,
  output logic [ADDR_W-1:0]  ram_addr,
  inout  wire  [DATA_W-1:0]  ram_data
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  sramState_t        state, stateNxt;
  grant_t            gnt, grantQ, grantNxt;
  logic [WAIT_W-1:0] waitCnt, waitCntNxt;
  logic              weQ, weNxt;
  logic              reqLoad, accessEnd;
  logic              busOe;
  logic [DATA_W-1:0] wdataQ;

  sram_prio_arb uArb (
    .req ({bus.mem_req, bus.if_req}),
    .gnt (gnt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      waitCnt <= '0;
      grantQ  <= GNT_NONE;
      weQ     <= 1'b0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitCntNxt;
      grantQ  <= grantNxt;
      weQ     <= weNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    waitCntNxt = waitCnt;
    grantNxt   = grantQ;
    weNxt      = weQ;
    reqLoad    = 1'b0;
    accessEnd  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt != GNT_NONE) begin
          stateNxt   = ACCESS;
          waitCntNxt = WAIT_LOAD;
          grantNxt   = gnt;
          weNxt      = (gnt == GNT_MEM) && bus.mem_we;
          reqLoad    = 1'b1;
        end
      end
      ACCESS: begin
        if (waitCnt == '0) begin
          stateNxt  = DONE;
          accessEnd = 1'b1;
        end else begin
          waitCntNxt = waitCnt - 1'b1;
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Strobes and bus enable are decoded from the next state so they leave
  // the flops aligned with the state they belong to.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ram_en_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      busOe        <= 1'b0;
      ram_addr     <= '0;
      bus.if_ack   <= 1'b0;
      bus.mem_ack  <= 1'b0;
      bus.if_rdata <= '0;
      bus.mem_rdata <= '0;
    end else begin
      ram_en_n    <= (stateNxt != ACCESS);
      ram_oe_n    <= !((stateNxt == ACCESS) && !weNxt);
      ram_we_n    <= !((stateNxt == ACCESS) && weNxt);
      busOe       <= weNxt && ((stateNxt == ACCESS) || (stateNxt == DONE));
      bus.if_ack  <= accessEnd && (grantQ == GNT_IF);
      bus.mem_ack <= accessEnd && (grantQ == GNT_MEM);
      if (reqLoad) begin
        ram_addr <= (gnt == GNT_MEM) ? bus.mem_addr : bus.if_addr;
      end
      if (accessEnd && !weQ) begin
        if (grantQ == GNT_IF) begin
          bus.if_rdata <= ram_data;
        end else if (grantQ == GNT_MEM) begin
          bus.mem_rdata <= ram_data;
        end
      end
    end
  end

  // Write data is pure datapath: captured at grant, no reset needed.
  always_ff @(posedge CLK) begin
    if (reqLoad) begin
      wdataQ <= bus.mem_wdata;
    end
  end

  assign ram_data = busOe ? wdataQ : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a WAIT_CYCLES=1 unit with a full
// SRAM model, plus WAIT_CYCLES=0 and 15 units for latency.
module tb_sram_port_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int W  = 1;

  logic clk = 1'b0;
  logic RST;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b15 ();

  logic          ramEnN, ramOeN, ramWeN;
  logic [AW-1:0] ramAddr;
  wire  [DW-1:0] ramData;
  logic          ram0EnN, ram0OeN, ram0WeN;
  logic [AW-1:0] ram0Addr;
  wire  [DW-1:0] ram0Data;
  logic          ram15EnN, ram15OeN, ram15WeN;
  logic [AW-1:0] ram15Addr;
  wire  [DW-1:0] ram15Data;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .CLK(clk), .RST(RST), .bus(bus),
    .ram_en_n(ramEnN), .ram_oe_n(ramOeN), .ram_we_n(ramWeN),
    .ram_addr(ramAddr), .ram_data(ramData)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u0 (
    .CLK(clk), .RST(RST), .bus(b0),
    .ram_en_n(ram0EnN), .ram_oe_n(ram0OeN), .ram_we_n(ram0WeN),
    .ram_addr(ram0Addr), .ram_data(ram0Data)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(15)) u15 (
    .CLK(clk), .RST(RST), .bus(b15),
    .ram_en_n(ram15EnN), .ram_oe_n(ram15OeN), .ram_we_n(ram15WeN),
    .ram_addr(ram15Addr), .ram_data(ram15Data)
  );

  // Asynchronous SRAM models: drive on output enable, write on clock edge.
  logic [DW-1:0] sram  [0:(1<<AW)-1];
  logic [DW-1:0] s0    [0:(1<<AW)-1];
  logic [DW-1:0] s15   [0:(1<<AW)-1];

  assign ramData   = (!ramEnN && !ramOeN)     ? sram[ramAddr]  : 16'hzzzz;
  assign ram0Data  = (!ram0EnN && !ram0OeN)   ? s0[ram0Addr]   : 16'hzzzz;
  assign ram15Data = (!ram15EnN && !ram15OeN) ? s15[ram15Addr] : 16'hzzzz;

  initial begin
    sram[18'h00010] = 16'hBEEF;
    sram[18'h00020] = 16'hCAFE;
    sram[18'h00200] = 16'h7777;
    sram[18'h00300] = 16'h0BAD;
    sram[18'h3FFFF] = 16'h0000;
    s0[18'h00010]   = 16'h1111;
    s15[18'h00010]  = 16'hF15F;
    forever begin
      @(posedge clk);
      if (!ramEnN && !ramWeN) sram[ramAddr] <= ramData;
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            issue;
    int            lat;
    logic          chk;
  } exp_t;

  exp_t ifQ[$];
  exp_t memQ[$];
  int   nChk = 0;
  int   nBad = 0;
  int   memAckCnt = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChk++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic reqIf(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
    logic got = 1'b0;
    ifQ.push_back('{data: d, issue: cyc, lat: lat, chk: 1'b1});
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.if_ack;
    end
    bus.if_req = 1'b0;
    if (!got) checkVal("if_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic reqMem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int lat);
    logic got = 1'b0;
    memQ.push_back('{data: rd, issue: cyc, lat: lat, chk: !we});
    bus.mem_we    = we;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_req   = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.mem_ack;
    end
    bus.mem_req = 1'b0;
    if (!got) checkVal("mem_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  // Bus-protocol and response monitor for the main unit.
  int            oeLow = 0;
  int            weLow = 0;
  logic          prevEnN = 1'b1;
  logic [DW-1:0] wrData = '0;

  initial forever begin : mon
    exp_t e;
    @(negedge clk);
    if (!RST) begin
      oeLow   = 0;
      weLow   = 0;
      prevEnN = 1'b1;
    end else begin
      if (!ramWeN) begin
        weLow++;
        wrData = ramData;
      end else if (weLow != 0) begin
        checkVal("we_low_cycles", 32'(weLow), 32'(W + 1));
        checkVal("wr_hold_drive", 32'(dut.busOe), 32'd1);
        checkVal("wr_hold_data", 32'(ramData), 32'(wrData));
        weLow = 0;
      end
      if (!ramOeN) begin
        oeLow++;
      end else if (oeLow != 0) begin
        checkVal("oe_low_cycles", 32'(oeLow), 32'(W + 1));
        oeLow = 0;
      end
      checkVal("strobe_overlap", 32'(ramOeN | ramWeN), 32'd1);
      if (ramEnN) checkVal("strobes_idle", 32'({ramOeN, ramWeN}), 32'd3);
      if (ramEnN && prevEnN) checkVal("bus_hiz_idle", 32'(dut.busOe), 32'd0);
      prevEnN = ramEnN;
      checkVal("ack_excl", 32'(bus.if_ack & bus.mem_ack), 32'd0);
      if (bus.if_ack) begin
        if (ifQ.size() == 0) begin
          checkVal("if_spurious_ack", 32'(bus.if_ack), 32'd0);
        end else begin
          e = ifQ.pop_front();
          checkVal("if_latency", 32'(cyc - e.issue), 32'(e.lat));
          if (e.chk) checkVal("if_rdata", 32'(bus.if_rdata), 32'(e.data));
        end
      end
      if (bus.mem_ack) begin
        memAckCnt++;
        if (memQ.size() == 0) begin
          checkVal("mem_spurious_ack", 32'(bus.mem_ack), 32'd0);
        end else begin
          e = memQ.pop_front();
          checkVal("mem_latency", 32'(cyc - e.issue), 32'(e.lat));
          if (e.chk) checkVal("mem_rdata", 32'(bus.mem_rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   t0;
    int   n0;
    RST = 1'b0;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    b0.if_req = 1'b0;   b0.if_addr = '0;
    b0.mem_req = 1'b0;  b0.mem_we = 1'b0;  b0.mem_addr = '0;  b0.mem_wdata = '0;
    b15.if_req = 1'b0;  b15.if_addr = '0;
    b15.mem_req = 1'b0; b15.mem_we = 1'b0; b15.mem_addr = '0; b15.mem_wdata = '0;

    repeat (3) @(posedge clk); #1;
    checkVal("rst_strobes", 32'({ramEnN, ramOeN, ramWeN}), 32'd7);
    checkVal("rst_addr", 32'(ramAddr), 32'd0);
    checkVal("rst_acks", 32'({bus.if_ack, bus.mem_ack}), 32'd0);
    checkVal("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
    checkVal("rst_mem_rdata", 32'(bus.mem_rdata), 32'd0);
    checkVal("rst_bus_drive", 32'(dut.busOe), 32'd0);
    RST = 1'b1;
    @(posedge clk); #1;

    reqIf(18'h00010, 16'hBEEF, W + 2);
    reqMem(1'b1, 18'h3FFFF, 16'h1234, 16'h0000, W + 2);
    reqMem(1'b0, 18'h3FFFF, 16'h0000, 16'h1234, W + 2);
    checkVal("if_rdata_hold", 32'(bus.if_rdata), 32'h0000BEEF);

    // Simultaneous requests: data port first, fetch port one full access later.
    fork
      reqMem(1'b0, 18'h3FFFF, 16'h0000, 16'h1234, W + 2);
      reqIf(18'h00020, 16'hCAFE, 2 * W + 5);
    join

    // Inputs change and req drops while the write is in flight.
    n0 = memAckCnt;
    memQ.push_back('{data: 16'h0000, issue: cyc, lat: W + 2, chk: 1'b0});
    bus.mem_we = 1'b1; bus.mem_addr = 18'h00100; bus.mem_wdata = 16'h5A5A; bus.mem_req = 1'b1;
    @(posedge clk); #1;
    bus.mem_addr = 18'h00200; bus.mem_wdata = 16'hDEAD; bus.mem_req = 1'b0;
    repeat (W + 6) @(posedge clk); #1;
    checkVal("mid_ack_once", 32'(memAckCnt - n0), 32'd1);
    checkVal("mem_rdata_hold", 32'(bus.mem_rdata), 32'h00001234);
    reqMem(1'b0, 18'h00100, 16'h0000, 16'h5A5A, W + 2);
    reqMem(1'b0, 18'h00200, 16'h0000, 16'h7777, W + 2);

    // Asynchronous reset in the middle of a write access.
    bus.mem_we = 1'b1; bus.mem_addr = 18'h00300; bus.mem_wdata = 16'h4444; bus.mem_req = 1'b1;
    @(posedge clk); #1;
    checkVal("pre_rst_we_low", 32'(ramWeN), 32'd0);
    RST = 1'b0;
    #1;
    checkVal("arst_strobes", 32'({ramEnN, ramOeN, ramWeN}), 32'd7);
    checkVal("arst_bus_drive", 32'(dut.busOe), 32'd0);
    checkVal("arst_addr", 32'(ramAddr), 32'd0);
    checkVal("arst_if_rdata", 32'(bus.if_rdata), 32'd0);
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checkVal("arst_no_ack", 32'({bus.if_ack, bus.mem_ack}), 32'd0);
    end
    RST = 1'b1;
    @(posedge clk); #1;
    reqIf(18'h00300, 16'h0BAD, W + 2);

    // WAIT_CYCLES = 0 unit.
    got = 1'b0; t0 = cyc;
    b0.if_addr = 18'h00010; b0.if_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      got = b0.if_ack;
      checkVal("w0_we_high", 32'(ram0WeN), 32'd1);
    end
    b0.if_req = 1'b0;
    checkVal("w0_ack_seen", 32'(got), 32'd1);
    checkVal("w0_latency", 32'(cyc - t0), 32'd2);
    checkVal("w0_rdata", 32'(b0.if_rdata), 32'h00001111);
    checkVal("w0_mem_ack", 32'(b0.mem_ack), 32'd0);
    @(posedge clk); #1;

    // WAIT_CYCLES = 15 unit.
    got = 1'b0; t0 = cyc;
    b15.if_addr = 18'h00010; b15.if_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      got = b15.if_ack;
      checkVal("w15_we_high", 32'(ram15WeN), 32'd1);
    end
    b15.if_req = 1'b0;
    checkVal("w15_ack_seen", 32'(got), 32'd1);
    checkVal("w15_latency", 32'(cyc - t0), 32'd17);
    checkVal("w15_rdata", 32'(b15.if_rdata), 32'h0000F15F);
    checkVal("w15_mem_ack", 32'(b15.mem_ack), 32'd0);

    repeat (3) @(posedge clk); #1;
    checkVal("w0_mem_rdata_idle", 32'(b0.mem_rdata), 32'd0);
    checkVal("w15_mem_rdata_idle", 32'(b15.mem_rdata), 32'd0);
    checkVal("if_queue_empty", 32'(ifQ.size()), 32'd0);
    checkVal("mem_queue_empty", 32'(memQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule
